// File: rtl/mfb_splitter_sched_pkg.sv
// Shared types and helpers for the MFB splitter scheduler.
// Holds the FSM state encoding and the switch-index width calculation.
package mfb_splitter_sched_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DRAINING   = 2'd1,
        DRAINED_ST = 2'd2
    } state_t;

    function automatic int idx_width(input int outputs);
        return (outputs > 1) ? $clog2(outputs) : 1;
    endfunction

endpackage

// File: rtl/mfb_splitter_sched_rr.sv
// Combinational multi-grant round-robin picker: assigns every valid item of a
// word to an eligible output, consuming one unit of remaining credit per grant.
module mfb_splitter_sched_rr
    import mfb_splitter_sched_pkg::*;
#(
    parameter  int ITEMS   = 2,
    parameter  int OUTPUTS = 4,
    parameter  int CW      = 5,
    localparam int IW      = idx_width(OUTPUTS)
) (
    input  logic [OUTPUTS-1:0]    i_elig,
    input  logic [OUTPUTS*CW-1:0] i_remaining,
    input  logic [IW-1:0]         i_ptr,
    input  logic [ITEMS-1:0]      i_vld,
    output logic [ITEMS*IW-1:0]   o_idx,
    output logic [IW-1:0]         o_next_ptr,
    output logic                  o_all_granted
);

    logic [CW-1:0] w_rem [OUTPUTS];
    logic [IW-1:0] w_ptr;
    logic [IW-1:0] w_cand;
    logic [IW-1:0] w_sel;
    logic          w_found;

    always_comb begin
        w_ptr         = i_ptr;
        w_cand        = '0;
        w_sel         = '0;
        w_found       = 1'b0;
        o_idx         = '0;
        o_all_granted = 1'b1;
        // Disabled outputs are modelled as having no credit left.
        for (int o = 0; o < OUTPUTS; o++) begin
            w_rem[o] = i_elig[o] ? i_remaining[o*CW +: CW] : '0;
        end
        for (int i = 0; i < ITEMS; i++) begin
            w_found = 1'b0;
            w_sel   = '0;
            if (i_vld[i]) begin
                // OUTPUTS is a power of two, so the IW-bit add wraps naturally.
                for (int k = 0; k < OUTPUTS; k++) begin
                    w_cand = w_ptr + IW'(k);
                    if (!w_found && w_rem[w_cand] != '0) begin
                        w_found = 1'b1;
                        w_sel   = w_cand;
                    end
                end
                if (w_found) begin
                    w_rem[w_sel] = w_rem[w_sel] - CW'(1);
                    w_ptr        = w_sel + IW'(1);
                end else begin
                    o_all_granted = 1'b0;
                end
            end
            o_idx[i*IW +: IW] = w_sel;
        end
        o_next_ptr = w_ptr;
    end

endmodule

// File: rtl/mfb_splitter_sched.sv
// Scheduler in front of the MFB splitter: tags each header with a splitter
// output chosen round-robin among enabled outputs with free credit.
module mfb_splitter_sched
    import mfb_splitter_sched_pkg::*;
#(
    parameter  int MVB_ITEMS = 2,
    parameter  int HDR_WIDTH = 128,
    parameter  int OUTPUTS   = 4,
    parameter  int CREDITS   = 16,
    localparam int IW        = idx_width(OUTPUTS)
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [MVB_ITEMS*HDR_WIDTH-1:0] RX_DATA,
    input  logic [MVB_ITEMS-1:0]           RX_VLD,
    input  logic                           RX_SRC_RDY,
    output logic                           RX_DST_RDY,
    output logic [MVB_ITEMS*HDR_WIDTH-1:0] TX_DATA,
    output logic [MVB_ITEMS*IW-1:0]        TX_SWITCH,
    output logic [MVB_ITEMS-1:0]           TX_VLD,
    output logic                           TX_SRC_RDY,
    input  logic                           TX_DST_RDY,
    input  logic [OUTPUTS-1:0]             OUT_ENABLE,
    input  logic [OUTPUTS-1:0]             CREDIT_RET,
    input  logic                           DRAIN_REQ,
    output logic                           DRAINED,
    output logic                           CREDIT_ERR
);

    localparam int CW = $clog2(CREDITS + 1);

    state_t                         r_state;
    state_t                         w_state_next;
    logic [IW-1:0]                  r_ptr;
    logic [MVB_ITEMS*HDR_WIDTH-1:0] r_tx_data;
    logic [MVB_ITEMS*IW-1:0]        r_tx_switch;
    logic [MVB_ITEMS-1:0]           r_tx_vld;
    logic                           r_tx_src_rdy;
    logic                           r_drained;
    logic                           r_credit_err;

    logic [OUTPUTS*CW-1:0]          w_remaining;
    logic [OUTPUTS-1:0]             w_cnt_zero;
    logic [OUTPUTS-1:0]             w_err_hit;
    logic [MVB_ITEMS*IW-1:0]        w_idx;
    logic [IW-1:0]                  w_next_ptr;
    logic                           w_all_granted;
    logic                           w_out_free;
    logic                           w_rx_xfer;

    mfb_splitter_sched_rr #(
        .ITEMS   (MVB_ITEMS),
        .OUTPUTS (OUTPUTS),
        .CW      (CW)
    ) u_rr (
        .i_elig        (OUT_ENABLE),
        .i_remaining   (w_remaining),
        .i_ptr         (r_ptr),
        .i_vld         (RX_VLD),
        .o_idx         (w_idx),
        .o_next_ptr    (w_next_ptr),
        .o_all_granted (w_all_granted)
    );

    assign w_out_free = !r_tx_src_rdy || TX_DST_RDY;
    assign RX_DST_RDY = (r_state == RUN) && w_all_granted && w_out_free;
    assign w_rx_xfer  = RX_SRC_RDY && RX_DST_RDY;

    generate
        for (genvar gi = 0; gi < OUTPUTS; gi++) begin : g_out
            logic [CW-1:0] r_cnt;
            logic [CW-1:0] w_assigned;

            always_comb begin
                w_assigned = '0;
                for (int i = 0; i < MVB_ITEMS; i++) begin
                    if (w_rx_xfer && RX_VLD[i] && (w_idx[i*IW +: IW] == IW'(gi))) begin
                        w_assigned = w_assigned + CW'(1);
                    end
                end
            end

            assign w_remaining[gi*CW +: CW] = CW'(CREDITS) - r_cnt;
            assign w_cnt_zero[gi]           = (r_cnt == '0);
            assign w_err_hit[gi]            = CREDIT_RET[gi] && (r_cnt == '0) && (w_assigned == '0);

            // A return with nothing in flight is ignored (and flagged) instead of wrapping.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_cnt <= '0;
                end else if (!w_err_hit[gi]) begin
                    r_cnt <= r_cnt + w_assigned - CW'(CREDIT_RET[gi]);
                end
            end
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (DRAIN_REQ) w_state_next = DRAINING;
            end
            DRAINING: begin
                if (!DRAIN_REQ) w_state_next = RUN;
                else if ((&w_cnt_zero) && !r_tx_src_rdy) w_state_next = DRAINED_ST;
            end
            DRAINED_ST: begin
                if (!DRAIN_REQ) w_state_next = RUN;
            end
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= RUN;
            r_ptr        <= '0;
            r_drained    <= 1'b0;
            r_credit_err <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_drained    <= (r_state == DRAINED_ST) && (w_state_next == DRAINED_ST);
            r_credit_err <= r_credit_err || (|w_err_hit);
            if (w_rx_xfer) r_ptr <= w_next_ptr;
        end
    end

    // Words with no valid item are accepted but never presented downstream.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_tx_src_rdy <= 1'b0;
            r_tx_vld     <= '0;
            r_tx_switch  <= '0;
            r_tx_data    <= '0;
        end else if (w_out_free) begin
            if (w_rx_xfer && (|RX_VLD)) begin
                r_tx_src_rdy <= 1'b1;
                r_tx_vld     <= RX_VLD;
                r_tx_switch  <= w_idx;
                r_tx_data    <= RX_DATA;
            end else begin
                r_tx_src_rdy <= 1'b0;
                r_tx_vld     <= '0;
            end
        end
    end

    assign TX_DATA    = r_tx_data;
    assign TX_SWITCH  = r_tx_switch;
    assign TX_VLD     = r_tx_vld;
    assign TX_SRC_RDY = r_tx_src_rdy;
    assign DRAINED    = r_drained;
    assign CREDIT_ERR = r_credit_err;

endmodule

// File: tb/tb_mfb_splitter_sched.sv
// Self-checking bench for mfb_splitter_sched: directed scenarios plus a
// randomized run against a behavioural scheduling/credit model.
module tb_mfb_splitter_sched;

    localparam int ITEMS = 2;
    localparam int HW    = 32;
    localparam int OUTS  = 4;
    localparam int CRED  = 2;
    localparam int IW    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic [ITEMS*HW-1:0]   rx_data;
    logic [ITEMS-1:0]      rx_vld;
    logic                  rx_src_rdy;
    logic                  rx_dst_rdy;
    logic [ITEMS*HW-1:0]   tx_data;
    logic [ITEMS*IW-1:0]   tx_switch;
    logic [ITEMS-1:0]      tx_vld;
    logic                  tx_src_rdy;
    logic                  tx_dst_rdy;
    logic [OUTS-1:0]       out_enable;
    logic [OUTS-1:0]       credit_ret;
    logic                  drain_req;
    logic                  drained;
    logic                  credit_err;

    mfb_splitter_sched #(
        .MVB_ITEMS (ITEMS),
        .HDR_WIDTH (HW),
        .OUTPUTS   (OUTS),
        .CREDITS   (CRED)
    ) dut (
        .CLK        (clk),
        .RESET      (reset),
        .RX_DATA    (rx_data),
        .RX_VLD     (rx_vld),
        .RX_SRC_RDY (rx_src_rdy),
        .RX_DST_RDY (rx_dst_rdy),
        .TX_DATA    (tx_data),
        .TX_SWITCH  (tx_switch),
        .TX_VLD     (tx_vld),
        .TX_SRC_RDY (tx_src_rdy),
        .TX_DST_RDY (tx_dst_rdy),
        .OUT_ENABLE (out_enable),
        .CREDIT_RET (credit_ret),
        .DRAIN_REQ  (drain_req),
        .DRAINED    (drained),
        .CREDIT_ERR (credit_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: state 0=run, 1=draining, 2=drained.
    int                  m_cnt [OUTS];
    int                  m_ptr, m_state, m_dcnt;
    bit                  m_err, m_tx_src, last_xfer;
    logic [ITEMS*HW-1:0] m_tx_data;
    logic [ITEMS-1:0]    m_tx_vld;
    logic [ITEMS*IW-1:0] m_tx_sw;
    bit                  e_rdy, e_ok;
    int                  e_sw  [ITEMS];
    int                  e_asg [OUTS];
    int                  e_next_ptr;

    function automatic void model_eval();
        int rem [OUTS];
        int p;
        bit f;
        p    = m_ptr;
        e_ok = 1'b1;
        for (int o = 0; o < OUTS; o++) begin
            rem[o]   = out_enable[o] ? (CRED - m_cnt[o]) : 0;
            e_asg[o] = 0;
        end
        for (int i = 0; i < ITEMS; i++) begin
            e_sw[i] = 0;
            if (rx_vld[i]) begin
                f = 1'b0;
                for (int k = 0; k < OUTS; k++) begin
                    if (!f && rem[(p + k) % OUTS] > 0) begin
                        f       = 1'b1;
                        e_sw[i] = (p + k) % OUTS;
                    end
                end
                if (f) begin
                    rem[e_sw[i]]--;
                    e_asg[e_sw[i]]++;
                    p = (e_sw[i] + 1) % OUTS;
                end else begin
                    e_ok = 1'b0;
                end
            end
        end
        e_next_ptr = p;
        e_rdy = (m_state == 0) && e_ok && (!m_tx_src || tx_dst_rdy);
    endfunction

    task automatic step();
        bit xfer, free, allz;
        int ns, a;
        model_eval();
        xfer = e_rdy && rx_src_rdy;
        free = !m_tx_src || tx_dst_rdy;
        allz = 1'b1;
        for (int o = 0; o < OUTS; o++) if (m_cnt[o] != 0) allz = 1'b0;
        ns = m_state;
        case (m_state)
            0:       if (drain_req) ns = 1;
            1:       if (!drain_req) ns = 0; else if (allz && !m_tx_src) ns = 2;
            default: if (!drain_req) ns = 0;
        endcase
        @(posedge clk);
        last_xfer = xfer;
        if (free) begin
            if (xfer && rx_vld != '0) begin
                m_tx_src  = 1'b1;
                m_tx_data = rx_data;
                m_tx_vld  = rx_vld;
                for (int i = 0; i < ITEMS; i++) m_tx_sw[i*IW +: IW] = IW'(e_sw[i]);
            end else begin
                m_tx_src = 1'b0;
            end
        end
        if (xfer) m_ptr = e_next_ptr;
        for (int o = 0; o < OUTS; o++) begin
            a = xfer ? e_asg[o] : 0;
            if (credit_ret[o] && (m_cnt[o] + a == 0)) m_err = 1'b1;
            else m_cnt[o] = m_cnt[o] + a - int'(credit_ret[o]);
        end
        m_dcnt  = (ns == 2) ? ((m_state == 2) ? m_dcnt + 1 : 1) : 0;
        m_state = ns;
        #1;
    endtask

    task automatic set_word(input logic [ITEMS-1:0] vld, input logic src);
        rx_vld     = vld;
        rx_src_rdy = src;
        rx_data    = {$urandom, $urandom};
    endtask

    task automatic return_all();
        logic [OUTS-1:0] mask;
        rx_src_rdy = 1'b0;
        for (int r = 0; r <= CRED; r++) begin
            for (int o = 0; o < OUTS; o++) mask[o] = (m_cnt[o] > 0);
            if (mask != '0) begin
                credit_ret = mask;
                step();
            end
        end
        credit_ret = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_vld = '0; rx_src_rdy = 1'b0; rx_data = '0; tx_dst_rdy = 1'b1;
        out_enable = '1; credit_ret = '0; drain_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (tx_src_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_src_rdy: got %b, expected 0", tx_src_rdy); end
        n_checks++; if (tx_vld !== '0) begin n_fail++; $display("FAIL reset_vld: got %b, expected 0", tx_vld); end
        n_checks++; if (tx_switch !== '0) begin n_fail++; $display("FAIL reset_switch: got %h, expected 0", tx_switch); end
        n_checks++; if (drained !== 1'b0) begin n_fail++; $display("FAIL reset_drained: got %b, expected 0", drained); end
        n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL reset_credit_err: got %b, expected 0", credit_err); end
        reset = 1'b0;
        for (int o = 0; o < OUTS; o++) m_cnt[o] = 0;
        m_ptr = 0; m_state = 0; m_dcnt = 0; m_err = 1'b0; m_tx_src = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (rx_dst_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rx_dst_rdy: got %b, expected 1", rx_dst_rdy); end
        $display("reset done");
    endtask

    task automatic test_basic_rr();
        logic [IW-1:0] exp_sw;
        out_enable = '1; tx_dst_rdy = 1'b1;
        for (int n = 0; n < 8; n++) begin
            set_word(2'b01, 1'b1);
            #1;
            n_checks++; if (rx_dst_rdy !== 1'b1) begin n_fail++; $display("FAIL rr_accept: word %0d got %b, expected 1", n, rx_dst_rdy); end
            step();
            exp_sw = IW'(n % OUTS);
            n_checks++;
            if (tx_src_rdy !== 1'b1 || tx_switch[IW-1:0] !== exp_sw || tx_data !== m_tx_data) begin
                n_fail++; $display("FAIL rr_switch: word %0d got src=%b sw=%0d, expected src=1 sw=%0d", n, tx_src_rdy, tx_switch[IW-1:0], exp_sw);
            end
            $display("rr word %0d: switch=%0d", n, tx_switch[IW-1:0]);
        end
        set_word(2'b00, 1'b0);
        step();
        n_checks++; if (tx_src_rdy !== 1'b0) begin n_fail++; $display("FAIL rr_flush: got %b, expected 0", tx_src_rdy); end
        return_all();
    endtask

    task automatic test_mask();
        logic [ITEMS*IW-1:0] exp_sw;
        exp_sw = {2'd3, 2'd1};
        out_enable = 4'b1010; tx_dst_rdy = 1'b1;
        for (int n = 0; n < 2; n++) begin
            set_word(2'b11, 1'b1);
            #1;
            n_checks++; if (rx_dst_rdy !== 1'b1) begin n_fail++; $display("FAIL mask_accept: word %0d got %b, expected 1", n, rx_dst_rdy); end
            step();
            n_checks++;
            if (tx_switch !== exp_sw || tx_vld !== 2'b11) begin
                n_fail++; $display("FAIL mask_switch: word %0d got %h vld=%b, expected %h vld=11", n, tx_switch, tx_vld, exp_sw);
            end
            $display("mask word %0d: switch=%h", n, tx_switch);
        end
        set_word(2'b11, 1'b1);
        #1;
        n_checks++; if (rx_dst_rdy !== 1'b0) begin n_fail++; $display("FAIL mask_full: got %b, expected 0", rx_dst_rdy); end
        set_word(2'b00, 1'b1);
        #1;
        n_checks++; if (rx_dst_rdy !== 1'b1) begin n_fail++; $display("FAIL empty_word_accept: got %b, expected 1", rx_dst_rdy); end
        step();
        n_checks++; if (tx_src_rdy !== 1'b0) begin n_fail++; $display("FAIL empty_word_drop: got %b, expected 0", tx_src_rdy); end
        return_all();
    endtask

    task automatic test_credit_exhaust();
        logic exp_rdy;
        out_enable = 4'b0100; tx_dst_rdy = 1'b1;
        for (int n = 0; n < 4; n++) begin
            set_word(2'b01, 1'b1);
            #1;
            exp_rdy = (n < CRED);
            n_checks++; if (rx_dst_rdy !== exp_rdy) begin n_fail++; $display("FAIL exhaust_rdy: word %0d got %b, expected %b", n, rx_dst_rdy, exp_rdy); end
            step();
        end
        credit_ret = 4'b0100;
        set_word(2'b01, 1'b1);
        #1;
        n_checks++; if (rx_dst_rdy !== 1'b0) begin n_fail++; $display("FAIL exhaust_same_cycle: got %b, expected 0", rx_dst_rdy); end
        step();
        credit_ret = '0;
        #1;
        n_checks++; if (rx_dst_rdy !== 1'b1) begin n_fail++; $display("FAIL exhaust_after_return: got %b, expected 1", rx_dst_rdy); end
        step();
        n_checks++; if (tx_src_rdy !== 1'b1 || tx_switch[IW-1:0] !== m_tx_sw[IW-1:0]) begin n_fail++; $display("FAIL exhaust_switch: got %0d, expected %0d", tx_switch[IW-1:0], m_tx_sw[IW-1:0]); end
        $display("exhaust extra word: switch=%0d", tx_switch[IW-1:0]);
        #1;
        n_checks++; if (rx_dst_rdy !== 1'b0) begin n_fail++; $display("FAIL exhaust_again: got %b, expected 0", rx_dst_rdy); end
        return_all();
    endtask

    task automatic test_backpressure();
        logic [ITEMS*HW-1:0] held_data;
        out_enable = '1; tx_dst_rdy = 1'b0;
        set_word(2'b01, 1'b1);
        held_data = rx_data;
        #1;
        n_checks++; if (rx_dst_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_first_accept: got %b, expected 1", rx_dst_rdy); end
        step();
        set_word(2'b11, 1'b1);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (rx_dst_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rx_blocked: cycle %0d got %b, expected 0", c, rx_dst_rdy); end
            step();
            n_checks++;
            if (tx_src_rdy !== 1'b1 || tx_data !== held_data || tx_switch !== m_tx_sw) begin
                n_fail++; $display("FAIL bp_hold: cycle %0d got data=%h sw=%h, expected data=%h sw=%h", c, tx_data, tx_switch, held_data, m_tx_sw);
            end
        end
        tx_dst_rdy = 1'b1;
        #1;
        n_checks++; if (rx_dst_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b, expected 1", rx_dst_rdy); end
        step();
        n_checks++; if (tx_switch !== m_tx_sw || tx_vld !== 2'b11) begin n_fail++; $display("FAIL bp_next_word: got sw=%h vld=%b, expected sw=%h vld=11", tx_switch, tx_vld, m_tx_sw); end
        $display("backpressure released: switch=%h", tx_switch);
        return_all();
        step();
    endtask

    task automatic test_drain();
        int saved_ptr;
        bit got;
        logic [IW-1:0] exp_sw;
        out_enable = '1; tx_dst_rdy = 1'b1;
        for (int n = 0; n < 3; n++) begin
            set_word(2'b01, 1'b1);
            step();
        end
        saved_ptr = m_ptr;
        rx_src_rdy = 1'b0; drain_req = 1'b1;
        step();
        set_word(2'b01, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (rx_dst_rdy !== 1'b0 || drained !== 1'b0) begin n_fail++; $display("FAIL drain_block: got rdy=%b drained=%b, expected 0 0", rx_dst_rdy, drained); end
            step();
        end
        for (int r = 0; r < 3; r++) begin
            credit_ret = '0;
            for (int o = OUTS - 1; o >= 0; o--) if (m_cnt[o] > 0) credit_ret = OUTS'(1) << o;
            #1;
            n_checks++; if (drained !== 1'b0) begin n_fail++; $display("FAIL drain_early: return %0d got %b, expected 0", r, drained); end
            step();
        end
        credit_ret = '0;
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            step();
            if (drained === 1'b1) got = 1'b1;
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL drain_done: got drained=%b, expected 1 within 6 cycles", drained); end
        n_checks++; if (rx_dst_rdy !== 1'b0) begin n_fail++; $display("FAIL drained_rx: got %b, expected 0", rx_dst_rdy); end
        $display("drained reached");
        drain_req = 1'b0; rx_src_rdy = 1'b0;
        step();
        step();
        n_checks++; if (drained !== 1'b0) begin n_fail++; $display("FAIL undrain: got %b, expected 0", drained); end
        set_word(2'b01, 1'b1);
        #1;
        n_checks++; if (rx_dst_rdy !== 1'b1) begin n_fail++; $display("FAIL resume_accept: got %b, expected 1", rx_dst_rdy); end
        step();
        exp_sw = IW'(saved_ptr);
        n_checks++; if (tx_switch[IW-1:0] !== exp_sw) begin n_fail++; $display("FAIL resume_ptr: got %0d, expected %0d", tx_switch[IW-1:0], exp_sw); end
        $display("resume word: switch=%0d", tx_switch[IW-1:0]);
        return_all();
    endtask

    task automatic test_random();
        drain_req = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) out_enable = OUTS'($urandom);
            set_word(ITEMS'($urandom), $urandom_range(0, 3) != 0);
            tx_dst_rdy = ($urandom_range(0, 9) < 7);
            for (int o = 0; o < OUTS; o++) credit_ret[o] = (m_cnt[o] > 0) && ($urandom_range(0, 2) == 0);
            #1;
            model_eval();
            n_checks++; if (rx_dst_rdy !== e_rdy) begin n_fail++; $display("FAIL rand_rx_dst_rdy: cycle %0d got %b, expected %b", c, rx_dst_rdy, e_rdy); end
            step();
            n_checks++; if (tx_src_rdy !== m_tx_src) begin n_fail++; $display("FAIL rand_src_rdy: cycle %0d got %b, expected %b", c, tx_src_rdy, m_tx_src); end
            if (m_tx_src) begin
                n_checks++;
                if (tx_vld !== m_tx_vld || tx_switch !== m_tx_sw || tx_data !== m_tx_data) begin
                    n_fail++; $display("FAIL rand_word: cycle %0d got vld=%b sw=%h, expected vld=%b sw=%h", c, tx_vld, tx_switch, m_tx_vld, m_tx_sw);
                end
            end
            n_checks++; if (credit_err !== m_err || drained !== 1'b0) begin n_fail++; $display("FAIL rand_flags: cycle %0d got err=%b drained=%b, expected err=%b drained=0", c, credit_err, drained, m_err); end
            if (last_xfer) $display("rand cycle %0d: accepted vld=%b", c, rx_vld);
        end
        set_word(2'b00, 1'b0);
        tx_dst_rdy = 1'b1;
        step();
        return_all();
    endtask

    task automatic test_simultaneous();
        out_enable = 4'b0010; tx_dst_rdy = 1'b1;
        set_word(2'b01, 1'b1);
        step();
        set_word(2'b01, 1'b1);
        credit_ret = 4'b0010;
        #1;
        n_checks++; if (rx_dst_rdy !== 1'b1) begin n_fail++; $display("FAIL simul_accept: got %b, expected 1", rx_dst_rdy); end
        step();
        credit_ret = '0;
        set_word(2'b01, 1'b1);
        #1;
        n_checks++; if (rx_dst_rdy !== 1'b1) begin n_fail++; $display("FAIL simul_net_one: got %b, expected 1", rx_dst_rdy); end
        step();
        set_word(2'b01, 1'b1);
        #1;
        n_checks++; if (rx_dst_rdy !== 1'b0) begin n_fail++; $display("FAIL simul_full: got %b, expected 0", rx_dst_rdy); end
        rx_src_rdy = 1'b0;
        n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b, expected 0", credit_err); end
        credit_ret = 4'b0001;
        step();
        credit_ret = '0;
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: cycle %0d got %b, expected 1", c, credit_err); end
            step();
        end
        $display("credit error flagged");
        return_all();
    endtask

    initial begin
        test_reset();
        test_basic_rr();
        test_mask();
        test_credit_exhaust();
        test_backpressure();
        test_drain();
        test_random();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
